// File: rtl/key_led_mode.sv
// -----------------------------------------------------------------------------
// key_led_mode
//
// Purpose:
//   Turns the 3-bit key-press count from the debounce/counter stage into one of
//   eight LED display modes. These are static, blinking, running-light and
//   binary counting patterns. A single shared period counter times every
//   pattern. Any change of the requested mode restarts both the counter and the
//   pattern on the same edge.
//
// Ports:
//   clk    in   1  system clock (50 MHz nominal)
//   rst_n  in   1  asynchronous, active-low reset
//   sum    in   3  requested mode (press count), synchronous to clk
//   led    out  4  LED drive, 1 = lit, registered
//   mode   out  3  currently active mode, registered
//
// Modes (the FSM state is the active mode itself):
//   mode | meaning
//   -----+---------------------------------------------------------
//   0    | all LEDs off, no timing
//   1    | all LEDs on, no timing
//   2    | slow blink 1111 <-> 0000, SLOW_CNT cycles per phase
//   3    | fast blink 1111 <-> 0000, FAST_CNT cycles per phase
//   4    | running light left  0001->0010->0100->1000, STEP_CNT/step
//   5    | running light right 1000->0100->0010->0001, STEP_CNT/step
//   6    | alternate 0101 <-> 1010, STEP_CNT per phase
//   7    | binary count 0000..1111 (wraps), STEP_CNT per step
// -----------------------------------------------------------------------------
module key_led_mode #(
  parameter int unsigned CNT_W    = 25,
  parameter int unsigned SLOW_CNT = 25_000_000,
  parameter int unsigned FAST_CNT = 5_000_000,
  parameter int unsigned STEP_CNT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sum,
  output logic [3:0] led,
  output logic [2:0] mode
);

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_ON    = 3'd1;
  localparam logic [2:0] MODE_SLOW  = 3'd2;
  localparam logic [2:0] MODE_FAST  = 3'd3;
  localparam logic [2:0] MODE_LEFT  = 3'd4;
  localparam logic [2:0] MODE_RIGHT = 3'd5;
  localparam logic [2:0] MODE_ALT   = 3'd6;
  localparam logic [2:0] MODE_COUNT = 3'd7;

  // Terminal-count values: the counter runs 0..P-1, so each LED value is
  // held for exactly P cycles.
  localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_CNT - 1);
  localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_CNT - 1);
  localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(STEP_CNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc;
  logic             has_period;
  logic             mode_change;
  logic             tick;

  // LED pattern that a mode starts from.
  function automatic logic [3:0] init_led(input logic [2:0] m);
    logic [3:0] v;
    case (m)
      MODE_ON,
      MODE_SLOW,
      MODE_FAST:  v = 4'b1111;
      MODE_LEFT:  v = 4'b0001;
      MODE_RIGHT: v = 4'b1000;
      MODE_ALT:   v = 4'b0101;
      MODE_COUNT: v = 4'b0000;
      default:    v = 4'b0000;
    endcase
    return v;
  endfunction

  // LED pattern after one period has elapsed in mode m.
  function automatic logic [3:0] next_led(input logic [2:0] m,
                                          input logic [3:0] cur);
    logic [3:0] v;
    case (m)
      MODE_SLOW,
      MODE_FAST,
      MODE_ALT:   v = ~cur;
      MODE_LEFT:  v = {cur[2:0], cur[3]};
      MODE_RIGHT: v = {cur[0], cur[3:1]};
      MODE_COUNT: v = cur + 4'd1;
      default:    v = 4'b0000;
    endcase
    return v;
  endfunction

  // Period selection for the active mode. Modes 0 and 1 are static and do
  // not run the counter.
  always_comb begin
    has_period = 1'b0;
    tc         = '0;
    case (mode)
      MODE_SLOW: begin
        has_period = 1'b1;
        tc         = SLOW_TC;
      end
      MODE_FAST: begin
        has_period = 1'b1;
        tc         = FAST_TC;
      end
      MODE_LEFT,
      MODE_RIGHT,
      MODE_ALT,
      MODE_COUNT: begin
        has_period = 1'b1;
        tc         = STEP_TC;
      end
      default: begin
        has_period = 1'b0;
        tc         = '0;
      end
    endcase
  end

  assign mode_change = (sum != mode);
  // A pending mode change suppresses the tick, so a change landing on the
  // terminal count still starts cleanly from the INIT pattern.
  assign tick        = has_period && (cnt == tc) && !mode_change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_OFF;
      led  <= 4'b0000;
      cnt  <= '0;
    end else if (mode_change) begin
      mode <= sum;
      led  <= init_led(sum);
      cnt  <= '0;
    end else if (tick) begin
      led  <= next_led(mode, led);
      cnt  <= '0;
    end else if (has_period) begin
      cnt  <= cnt + 1'b1;
    end else begin
      // Static modes: keep the counter parked and the pattern pinned.
      led  <= init_led(mode);
      cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_key_led_mode.sv
module tb_key_led_mode;

  localparam int SLOW = 10;
  localparam int FAST = 4;
  localparam int STEP = 6;

  logic       clk;
  logic       rst_n;
  logic [2:0] sum;
  logic [3:0] led;
  logic [2:0] mode;

  int errors;
  int checks;

  // Reference state: the active mode and the number of edges since entering it.
  int m_mode;
  int m_k;

  key_led_mode #(
    .CNT_W   (8),
    .SLOW_CNT(SLOW),
    .FAST_CNT(FAST),
    .STEP_CNT(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sum  (sum),
    .led  (led),
    .mode (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected LED value from the mode and time elapsed since entering it.
  function automatic logic [3:0] exp_led(input int md, input int k);
    int step;
    logic [3:0] v;
    v = 4'b0000;
    case (md)
      0: v = 4'b0000;
      1: v = 4'b1111;
      2: begin step = k / SLOW; v = (step % 2 == 0) ? 4'b1111 : 4'b0000; end
      3: begin step = k / FAST; v = (step % 2 == 0) ? 4'b1111 : 4'b0000; end
      4: begin step = k / STEP; v = 4'(1 << (step % 4)); end
      5: begin step = k / STEP; v = 4'(8 >> (step % 4)); end
      6: begin step = k / STEP; v = (step % 2 == 0) ? 4'b0101 : 4'b1010; end
      7: begin step = k / STEP; v = 4'(step % 16); end
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the sum seen at the edge, then
  // compare outputs 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (int'(sum) != m_mode) begin
      m_mode = int'(sum);
      m_k    = 0;
    end else begin
      m_k++;
    end
    #1;
    chk3({tag, "_mode"}, mode, 3'(m_mode));
    chk4({tag, "_led"}, led, exp_led(m_mode, m_k));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_mode = 0;
    m_k    = 0;
    rst_n  = 1'b0;
    sum    = 3'd0;

    #2;
    chk4("reset_led", led, 4'b0000);
    chk3("reset_mode", mode, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("static0", 50);
    sum = 3'd1;
    cycle("enter1");
    chk4("enter1_direct", led, 4'b1111);
    run("static1", 50);

    sum = 3'd2;
    run("slow", 25);
    sum = 3'd3;
    run("fast", 20);

    sum = 3'd4;
    run("left", 30);
    sum = 3'd5;
    run("right", 30);

    sum = 3'd7;
    run("count", 100);
    sum = 3'd0;
    cycle("wrap0");
    chk4("wrap0_direct", led, 4'b0000);
    chk3("wrap0_mode", mode, 3'd0);

    // Mode change arriving exactly at the terminal count of mode 2.
    sum = 3'd2;
    cycle("tc_enter");
    run("tc_count", 9);
    sum = 3'd6;
    cycle("tc_change");
    chk4("tc_change_direct", led, 4'b0101);
    run("tc_alt", 5);
    chk4("tc_alt_hold", led, 4'b0101);
    cycle("tc_alt_step");
    chk4("tc_alt_step_direct", led, 4'b1010);

    // Asynchronous reset in the middle of the running-light pattern.
    sum = 3'd4;
    run("pre_rst", 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst_led", led, 4'b0000);
    chk3("async_rst_mode", mode, 3'd0);
    m_mode = 0;
    m_k    = 0;
    #2;
    rst_n = 1'b1;
    cycle("post_rst");
    chk4("post_rst_direct", led, 4'b0001);
    run("post_rst_run", 12);

    // Randomized mode requests, including back-to-back changes.
    for (int i = 0; i < 200; i++) begin
      sum = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) run("rnd_short", 1);
      else run("rnd", $urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
